// File: rtl/cp0_defines.sv
// Shared CP0 definitions: register numbers, encoded exception types from the
// exception unit, architectural ExcCode values, Status/Cause field positions
// and reset values. Imported by cp0_regfile and cp0_timer.
package cp0_defines;

    // CP0 register numbers
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    // Encoded except_type values from the exception unit
    localparam logic [31:0] EXT_INT     = 32'h1;
    localparam logic [31:0] EXT_ADEL    = 32'h4;
    localparam logic [31:0] EXT_ADES    = 32'h5;
    localparam logic [31:0] EXT_SYSCALL = 32'h8;
    localparam logic [31:0] EXT_BREAK   = 32'h9;
    localparam logic [31:0] EXT_RI      = 32'hA;
    localparam logic [31:0] EXT_OV      = 32'hC;
    localparam logic [31:0] EXT_ERET    = 32'hE;

    // Architectural ExcCode values
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    // Status / Cause field positions
    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_EXL = 1;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    // Reset values
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    // True for every except_type that raises an exception (ERET excluded).
    function automatic logic is_exception(input logic [31:0] t);
        return (t == EXT_INT) || (t == EXT_ADEL) || (t == EXT_ADES) ||
               (t == EXT_SYSCALL) || (t == EXT_BREAK) || (t == EXT_RI) ||
               (t == EXT_OV);
    endfunction

    // ExcCode for a raising except_type; only meaningful when is_exception().
    function automatic logic [4:0] exc_code(input logic [31:0] t);
        logic [4:0] c;
        c = EXC_INT;
        case (t)
            EXT_ADEL:    c = EXC_ADEL;
            EXT_ADES:    c = EXC_ADES;
            EXT_SYSCALL: c = EXC_SYSCALL;
            EXT_BREAK:   c = EXC_BREAK;
            EXT_RI:      c = EXC_RI;
            EXT_OV:      c = EXC_OV;
            default:     c = EXC_INT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer.
// Ports: clk, resetn (sync, active-low); count_we/compare_we with shared
// wdata (MTC0 path); count, compare current values; timer_int = Cause.TI.
// Count advances every second cycle via a free-running tick toggle.
module cp0_timer
    import cp0_defines::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic        tick;
    logic [31:0] count_inc;

    assign count_inc = count + 32'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick      <= 1'b0;
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            tick <= ~tick;

            // A written Count replaces the increment and never raises TI.
            if (count_we) begin
                count <= wdata;
            end else if (tick) begin
                count <= count_inc;
            end

            // Compare write clears TI even against a same-cycle match.
            if (compare_we) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if (!count_we && tick && (count_inc == compare)) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception commit controller.
// Ports: clk, resetn (sync, active-low); MTC0 we_i/waddr_i/wdata_i;
// MFC0 raddr_i -> rdata_o (combinational); int_i hardware interrupts;
// except_type_i/pc_i/in_delayslot_i/badvaddr_i exception commit inputs;
// status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o register values;
// timer_int_o = Cause.TI.
module cp0_regfile
    import cp0_defines::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VAL = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] badvaddr_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    logic [31:0] status;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic        cause_bd;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc;

    logic        raise;
    logic        eret;
    logic        commit;
    logic        mtc0;

    always_comb begin
        raise  = is_exception(except_type_i);
        eret   = (except_type_i == EXT_ERET);
        commit = raise | eret;
        // A committing instruction squashes the MTC0 in the same cycle.
        mtc0   = we_i & ~commit;
    end

    cp0_timer u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (mtc0 && (waddr_i == REG_COUNT)),
        .compare_we (mtc0 && (waddr_i == REG_COMPARE)),
        .wdata      (wdata_i),
        .count      (count_o),
        .compare    (compare_o),
        .timer_int  (timer_int_o)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            status      <= STATUS_RESET;
            epc         <= '0;
            badvaddr    <= '0;
            cause_bd    <= 1'b0;
            cause_ip_hw <= '0;
            cause_ip_sw <= '0;
            cause_exc   <= '0;
        end else begin
            // IP7 is shared between int_i[5] and the timer.
            cause_ip_hw <= {int_i[5] | timer_int_o, int_i[4:0]};

            if (raise) begin
                cause_exc <= exc_code(except_type_i);
                if (!status[STATUS_EXL]) begin
                    epc      <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                    cause_bd <= in_delayslot_i;
                end
                status[STATUS_EXL] <= 1'b1;
                if ((except_type_i == EXT_ADEL) || (except_type_i == EXT_ADES)) begin
                    badvaddr <= badvaddr_i;
                end
            end else if (eret) begin
                status[STATUS_EXL] <= 1'b0;
            end else if (mtc0) begin
                case (waddr_i)
                    REG_STATUS: status <= (status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
                    REG_CAUSE:  cause_ip_sw <= wdata_i[9:8];
                    REG_EPC:    epc <= wdata_i;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        status_o   = status;
        epc_o      = epc;
        badvaddr_o = badvaddr;
        cause_o    = {cause_bd, timer_int_o, 14'b0, cause_ip_hw, cause_ip_sw,
                      1'b0, cause_exc, 2'b00};
    end

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            REG_BADVADDR: rdata_o = badvaddr;
            REG_COUNT:    rdata_o = count_o;
            REG_COMPARE:  rdata_o = compare_o;
            REG_STATUS:   rdata_o = status_o;
            REG_CAUSE:    rdata_o = cause_o;
            REG_EPC:      rdata_o = epc;
            REG_PRID:     rdata_o = PRID_VAL;
            REG_CONFIG:   rdata_o = CONFIG_VAL;
            default:      rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        resetn;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic [31:0] except_type_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] badvaddr_i;
    logic [31:0] status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
    logic        timer_int_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_regfile #(
        .PRID_VAL   (32'h0000_4220),
        .CONFIG_VAL (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .int_i          (int_i),
        .except_type_i  (except_type_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .badvaddr_i     (badvaddr_i),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .count_o        (count_o),
        .compare_o      (compare_o),
        .badvaddr_o     (badvaddr_o),
        .timer_int_o    (timer_int_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        raddr_i = a;
        #1;
        d = rdata_o;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        step();
        we_i = 1'b0;
    endtask

    task automatic raise(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                         input logic [31:0] bad);
        except_type_i = t; pc_i = pc; in_delayslot_i = ds; badvaddr_i = bad;
        step();
        except_type_i = '0; in_delayslot_i = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        bit seen;

        resetn = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
        int_i = '0; except_type_i = '0; pc_i = '0; in_delayslot_i = 1'b0;
        badvaddr_i = '0;
        step(); step();

        // Reset state
        rd(5'd12, d); check("reset_status", d, 32'h0040_0000);
        rd(5'd13, d); check("reset_cause", d, 32'h0);
        rd(5'd14, d); check("reset_epc", d, 32'h0);
        rd(5'd15, d); check("prid", d, 32'h0000_4220);
        rd(5'd16, d); check("config", d, 32'h8000_0000);
        check("reset_count", count_o, 32'h0);
        check("reset_ti", {31'b0, timer_int_o}, 32'h0);
        resetn = 1'b1;

        // AdEL in a delay slot
        raise(32'h4, 32'hBFC0_0100, 1'b1, 32'h1);
        check("adel_epc", epc_o, 32'hBFC0_00FC);
        check("adel_bd", {31'b0, cause_o[31]}, 32'h1);
        check("adel_exc", {27'b0, cause_o[6:2]}, 32'd4);
        check("adel_badvaddr", badvaddr_o, 32'h1);
        check("adel_exl", {31'b0, status_o[1]}, 32'h1);

        // Nested syscall while EXL=1: EPC/BD hold, ExcCode updates
        raise(32'h8, 32'h0000_0200, 1'b0, 32'hDEAD_0000);
        check("nest_epc", epc_o, 32'hBFC0_00FC);
        check("nest_exc", {27'b0, cause_o[6:2]}, 32'd8);
        check("nest_bd", {31'b0, cause_o[31]}, 32'h1);
        check("nest_badvaddr", badvaddr_o, 32'h1);

        // ERET
        raise(32'hE, 32'h0000_0300, 1'b0, 32'h0);
        check("eret_exl", {31'b0, status_o[1]}, 32'h0);
        check("eret_epc", epc_o, 32'hBFC0_00FC);
        check("eret_exc", {27'b0, cause_o[6:2]}, 32'd8);

        // Timer: Compare=5, Count=0, wait for TI
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        check("count_written", count_o, 32'h0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (timer_int_o) seen = 1;
            else step();
        end
        check("ti_rise", {31'b0, seen}, 32'h1);
        check("ti_count", count_o, 32'd5);
        check("ti_cause30", {31'b0, cause_o[30]}, 32'h1);
        step();
        check("ti_cause15", {31'b0, cause_o[15]}, 32'h1);
        mtc0(5'd11, 32'd100);
        check("ti_clear", {31'b0, timer_int_o}, 32'h0);
        check("ti_clear_c30", {31'b0, cause_o[30]}, 32'h0);
        // Writing Count equal to Compare must not raise TI
        mtc0(5'd9, 32'd100);
        check("count_eq_no_ti", {31'b0, timer_int_o}, 32'h0);
        step();

        // Status / Cause write masks
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, d); check("status_mask", d, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, d); check("cause_mask", d, 32'h8000_0320);

        // Read-only / unlisted registers
        mtc0(5'd15, 32'h0);
        rd(5'd15, d); check("prid_ro", d, 32'h0000_4220);
        mtc0(5'd8, 32'h5555_5555);
        check("badvaddr_ro", badvaddr_o, 32'h1);
        mtc0(5'd3, 32'hFFFF_FFFF);
        rd(5'd3, d); check("unlisted", d, 32'h0);

        // Commit beats simultaneous MTC0
        mtc0(5'd12, 32'h0);
        we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h1234;
        raise(32'h1, 32'h80, 1'b0, 32'h0);
        we_i = 1'b0;
        check("collide_epc", epc_o, 32'h80);
        check("collide_exc", {27'b0, cause_o[6:2]}, 32'd0);
        check("collide_status", status_o, 32'h0040_0002);
        check("collide_bd", {31'b0, cause_o[31]}, 32'h0);

        // Hardware interrupt lines into IP[15:10]
        int_i = 6'b100001;
        step();
        check("hw_ip", {26'b0, cause_o[15:10]}, 32'h21);
        int_i = '0;

        // Unknown nonzero code ignored
        raise(32'h3, 32'h400, 1'b0, 32'h0);
        check("ignored_epc", epc_o, 32'h80);

        // Reset mid-count with TI pending
        mtc0(5'd11, 32'd3);
        mtc0(5'd9, 32'd0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (timer_int_o) seen = 1;
            else step();
        end
        check("ti2_rise", {31'b0, seen}, 32'h1);
        resetn = 1'b0;
        step();
        check("rst_count", count_o, 32'h0);
        check("rst_ti", {31'b0, timer_int_o}, 32'h0);
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_epc", epc_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
